// File: rtl/mux_scan_n_if.sv
// Bus bundle for mux_scan_n: packed channel inputs, select/scan controls,
// and the registered display outputs.
interface mux_scan_n_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] d;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           en;
  logic [N-1:0]   mask;
  logic [W-1:0]   out;
  logic [SW-1:0]  ch;
  logic           valid;
  logic           wrap;

  modport master (
    output d, sel, mode, en, mask,
    input  out, ch, valid, wrap
  );

  modport slave (
    input  d, sel, mode, en, mask,
    output out, ch, valid, wrap
  );
endinterface

// File: rtl/mux_scan_n.sv
// N-channel W-bit multiplexer with registered output; direct select or a
// round-robin scan over the masked channels, dwelling HOLD cycles on each.
module mux_scan_n #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int HOLD = 1
) (
  input logic          clk,
  input logic          reset,
  mux_scan_n_if.slave  bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(HOLD) + 1;
  localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD - 1);

  logic [W-1:0]  r_out;
  logic [SW-1:0] r_ch;
  logic          r_valid;
  logic          r_wrap;
  logic [SW-1:0] r_p;
  logic [CW-1:0] r_cnt;
  logic          r_mode_q;

  logic [SW-1:0] w_low;
  logic [SW-1:0] w_next;
  logic          w_found_after;
  logic          w_next_wrap;
  logic          w_cur_en;
  logic          w_sel_ok;
  logic [W-1:0]  w_sel_data;
  logic [SW-1:0] w_s;
  logic [W-1:0]  w_s_data;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_wrap_nxt;

  // Channel search and next-state selection for both modes
  always_comb begin
    w_low         = '0;
    w_next        = '0;
    w_found_after = 1'b0;
    w_cur_en      = 1'b0;
    w_sel_ok      = 1'b0;
    w_sel_data    = '0;
    w_s_data      = '0;
    // Descending scan leaves the lowest enabled channel in w_low
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.mask[i]) begin
        w_low = SW'(i);
      end else begin
        w_low = w_low;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found_after && bus.mask[i] && (SW'(i) > r_p)) begin
        w_next        = SW'(i);
        w_found_after = 1'b1;
      end else begin
        w_next        = w_next;
      end
      if (SW'(i) == r_p) begin
        w_cur_en = bus.mask[i];
      end else begin
        w_cur_en = w_cur_en;
      end
      if (SW'(i) == bus.sel) begin
        w_sel_ok   = 1'b1;
        w_sel_data = bus.d[i*W +: W];
      end else begin
        w_sel_ok   = w_sel_ok;
      end
    end
    // Nothing enabled above p: the sweep wraps to the lowest enabled channel
    if (w_found_after) begin
      w_next_wrap = 1'b0;
    end else begin
      w_next      = w_low;
      w_next_wrap = 1'b1;
    end

    if (!r_mode_q) begin
      w_s        = w_low;
      w_cnt_nxt  = '0;
      w_wrap_nxt = 1'b0;
    end else if ((r_cnt == HOLD_M1) || !w_cur_en) begin
      w_s        = w_next;
      w_cnt_nxt  = '0;
      w_wrap_nxt = w_next_wrap;
    end else begin
      w_s        = r_p;
      w_cnt_nxt  = r_cnt + CW'(1);
      w_wrap_nxt = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      if (SW'(i) == w_s) begin
        w_s_data = bus.d[i*W +: W];
      end else begin
        w_s_data = w_s_data;
      end
    end
  end

  // Output, scan pointer, dwell counter and mode history registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_ch     <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
      r_p      <= '0;
      r_cnt    <= '0;
      r_mode_q <= 1'b0;
    end else if (!bus.en) begin
      r_wrap <= 1'b0;
    end else begin
      r_mode_q <= bus.mode;
      if (!bus.mode) begin
        r_out   <= w_sel_ok ? w_sel_data : '0;
        r_ch    <= bus.sel;
        r_valid <= w_sel_ok;
        r_wrap  <= 1'b0;
        r_cnt   <= '0;
      end else if (bus.mask == '0) begin
        r_out   <= '0;
        r_ch    <= r_p;
        r_valid <= 1'b0;
        r_wrap  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_p     <= w_s;
        r_cnt   <= w_cnt_nxt;
        r_wrap  <= w_wrap_nxt;
        r_out   <= w_s_data;
        r_ch    <= w_s;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.out   = r_out;
  assign bus.ch    = r_ch;
  assign bus.valid = r_valid;
  assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: four instances (varying N/HOLD) share one directed
// stimulus; a list-based model is compared every cycle, plus literal checks.
module tb_mux_scan_n;
  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] d     = 32'h44332211;
  logic [1:0]  sel   = 2'd0;
  logic        mode  = 1'b0;
  logic        en    = 1'b0;
  logic [3:0]  mask  = 4'h0;
  logic        cmp_on = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  mux_scan_n_if #(.W(8), .N(4)) ifa ();
  mux_scan_n_if #(.W(8), .N(4)) ifb ();
  mux_scan_n_if #(.W(8), .N(4)) ifc ();
  mux_scan_n_if #(.W(8), .N(3)) ifd ();

  assign ifa.d = d;        assign ifb.d = d;        assign ifc.d = d;        assign ifd.d = d[23:0];
  assign ifa.sel = sel;    assign ifb.sel = sel;    assign ifc.sel = sel;    assign ifd.sel = sel;
  assign ifa.mode = mode;  assign ifb.mode = mode;  assign ifc.mode = mode;  assign ifd.mode = mode;
  assign ifa.en = en;      assign ifb.en = en;      assign ifc.en = en;      assign ifd.en = en;
  assign ifa.mask = mask;  assign ifb.mask = mask;  assign ifc.mask = mask;  assign ifd.mask = mask[2:0];

  mux_scan_n #(.W(8), .N(4), .HOLD(1)) u_a (.clk(clk), .reset(reset), .bus(ifa));
  mux_scan_n #(.W(8), .N(4), .HOLD(2)) u_b (.clk(clk), .reset(reset), .bus(ifb));
  mux_scan_n #(.W(8), .N(4), .HOLD(4)) u_c (.clk(clk), .reset(reset), .bus(ifc));
  mux_scan_n #(.W(8), .N(3), .HOLD(1)) u_d (.clk(clk), .reset(reset), .bus(ifd));

  int          ns [4] = '{4, 4, 4, 3};
  int          hs [4] = '{1, 2, 4, 1};
  int          m_p   [4];
  int          m_shown [4];
  bit          m_prev_scan [4];
  logic [7:0]  e_out   [4];
  logic [1:0]  e_ch    [4];
  logic        e_valid [4];
  logic        e_wrap  [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: channel shown for HOLD cycles; next is the first enabled channel
  // above the current one in an ascending list, else the list head (a wrap).
  task automatic model_step(input int k);
    int lst[$];
    int s;
    if (!en) begin
      e_wrap[k] = 1'b0;
      return;
    end
    for (int i = 0; i < ns[k]; i++) if (mask[i]) lst.push_back(i);
    if (!mode) begin
      e_ch[k] = sel;
      e_wrap[k] = 1'b0;
      m_shown[k] = 0;
      if (int'(sel) < ns[k]) begin
        e_out[k] = d[sel*8 +: 8];
        e_valid[k] = 1'b1;
      end else begin
        e_out[k] = 8'h00;
        e_valid[k] = 1'b0;
      end
    end else if (lst.size() == 0) begin
      e_out[k] = 8'h00;
      e_valid[k] = 1'b0;
      e_ch[k] = 2'(m_p[k]);
      e_wrap[k] = 1'b0;
      m_shown[k] = 0;
    end else begin
      e_wrap[k] = 1'b0;
      if (!m_prev_scan[k]) begin
        s = lst[0];
        m_shown[k] = 0;
      end else if (m_shown[k] + 1 >= hs[k] || !mask[m_p[k]]) begin
        s = -1;
        foreach (lst[j]) if (s < 0 && lst[j] > m_p[k]) s = lst[j];
        if (s < 0) begin
          s = lst[0];
          e_wrap[k] = 1'b1;
        end
        m_shown[k] = 0;
      end else begin
        s = m_p[k];
        m_shown[k] = m_shown[k] + 1;
      end
      m_p[k] = s;
      e_out[k] = d[s*8 +: 8];
      e_ch[k] = 2'(s);
      e_valid[k] = 1'b1;
    end
    m_prev_scan[k] = mode;
  endtask

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        m_p[k] = 0; m_shown[k] = 0; m_prev_scan[k] = 1'b0;
        e_out[k] = 8'h00; e_ch[k] = 2'd0; e_valid[k] = 1'b0; e_wrap[k] = 1'b0;
      end else begin
        model_step(k);
      end
    end
  end

  task automatic cmp(input int k, input logic [7:0] o, input logic [1:0] c, input logic v, input logic w);
    chk($sformatf("model%0d_out", k), o, e_out[k]);
    chk($sformatf("model%0d_ch", k), c, e_ch[k]);
    chk($sformatf("model%0d_valid", k), v, e_valid[k]);
    chk($sformatf("model%0d_wrap", k), w, e_wrap[k]);
  endtask

  always @(negedge clk) begin
    if (cmp_on && !reset) begin
      cmp(0, ifa.out, ifa.ch, ifa.valid, ifa.wrap);
      cmp(1, ifb.out, ifb.ch, ifb.valid, ifb.wrap);
      cmp(2, ifc.out, ifc.ch, ifc.valid, ifc.wrap);
      cmp(3, ifd.out, ifd.ch, ifd.valid, ifd.wrap);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t2_out [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  logic [1:0] t3_ch  [6] = '{2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1};
  logic [7:0] t3_out [6] = '{8'h22, 8'h22, 8'h44, 8'h44, 8'h22, 8'h22};
  logic [3:0] mtab   [12] = '{4'hF, 4'hF, 4'h3, 4'h6, 4'h6, 4'h8, 4'h8, 4'h0, 4'h9, 4'h9, 4'hD, 4'h5};

  initial begin
    #1 reset = 1'b1;
    #1;
    chk("rst_out", ifa.out, 8'h00);
    chk("rst_ch", ifa.ch, 2'd0);
    chk("rst_valid", ifa.valid, 1'b0);
    chk("rst_wrap", ifa.wrap, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    cmp_on = 1'b1;

    en = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    chk("direct_out", ifa.out, 8'h33);
    chk("direct_ch", ifa.ch, 2'd2);
    chk("direct_valid", ifa.valid, 1'b1);
    chk("direct_wrap", ifa.wrap, 1'b0);

    sel = 2'd3;
    tick();
    chk("n3_sel3_valid", ifd.valid, 1'b0);
    chk("n3_sel3_out", ifd.out, 8'h00);
    chk("n3_sel3_ch", ifd.ch, 2'd3);
    sel = 2'd0;
    tick();
    chk("n3_sel0_out", ifd.out, 8'h11);
    chk("n3_sel0_valid", ifd.valid, 1'b1);

    mode = 1'b1; mask = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("scan_h1_out%0d", i), ifa.out, t2_out[i]);
      chk($sformatf("scan_h1_wrap%0d", i), ifa.wrap, (i == 4) ? 1'b1 : 1'b0);
    end

    mode = 1'b0;
    tick();
    mode = 1'b1; mask = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("scan_h2_ch%0d", i), ifb.ch, t3_ch[i]);
      chk($sformatf("scan_h2_out%0d", i), ifb.out, t3_out[i]);
      chk($sformatf("scan_h2_wrap%0d", i), ifb.wrap, (i == 4) ? 1'b1 : 1'b0);
    end

    mode = 1'b0;
    tick();
    mode = 1'b1; mask = 4'b1111;
    repeat (5) tick();
    chk("h4_at_ch1", ifc.ch, 2'd1);
    mask = 4'b0000;
    tick();
    chk("h4_empty_valid", ifc.valid, 1'b0);
    chk("h4_empty_out", ifc.out, 8'h00);
    mask = 4'b0100;
    tick();
    chk("h4_resume_ch", ifc.ch, 2'd2);
    chk("h4_resume_out", ifc.out, 8'h33);
    chk("h4_resume_valid", ifc.valid, 1'b1);
    chk("h4_resume_wrap", ifc.wrap, 1'b0);

    mask = 4'b1111;
    tick();
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_out", ifa.out, 8'h00);
    chk("midrst_ch", ifa.ch, 2'd0);
    chk("midrst_valid", ifa.valid, 1'b0);
    chk("midrst_wrap", ifa.wrap, 1'b0);
    chk("midrst_c_valid", ifc.valid, 1'b0);
    #1 reset = 1'b0;
    tick();
    chk("post_rst_entry_ch", ifa.ch, 2'd0);
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("frozen_ch%0d", i), ifa.ch, 2'd1);
      chk($sformatf("frozen_out%0d", i), ifa.out, 8'h22);
      chk($sformatf("frozen_wrap%0d", i), ifa.wrap, 1'b0);
    end
    en = 1'b1;
    repeat (3) tick();
    chk("sweep_wrap", ifa.wrap, 1'b1);
    chk("sweep_wrap_ch", ifa.ch, 2'd0);
    en = 1'b0;
    tick();
    chk("en0_wrap_forced", ifa.wrap, 1'b0);
    chk("en0_out_held", ifa.out, 8'h11);
    en = 1'b1;

    mode = 1'b0;
    tick();
    mode = 1'b1; mask = 4'b0001;
    tick();
    chk("single_entry_wrap", ifa.wrap, 1'b0);
    tick();
    chk("single_self_wrap", ifa.wrap, 1'b1);
    chk("single_self_out", ifa.out, 8'h11);

    for (int i = 0; i < 12; i++) begin
      mask = mtab[i];
      tick();
    end
    mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
    end
    tick();
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
